// File: rtl/enigma_top.sv
// Enigma I (rotors I-II-III, reflector UKW-B, rings A, no plugboard) behind a UART.
// Letters received while idle are folded to uppercase, the rotors step, and the
// enciphered letter is sent back; any other byte is echoed unchanged.
// Optional macro ENIGMA_BANNER_EN: when defined, "ENIGMA-I READY\r\n" is sent after reset.
// Ports:
//   clk      system clock, rising edge
//   ext_rst  synchronous active-high reset
//   uart_rx  UART receive line (8N1, idle high, asynchronous)
//   uart_tx  UART transmit line (8N1, idle high)
//   led_d1   controller idle      led_d2  RX frame in progress
//   led_d3   TX busy              led_d4  toggles per enciphered letter
//   led_d5   out of reset
module enigma_top #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic clk,
  input  logic ext_rst,
  input  logic uart_rx,
  output logic uart_tx,
  output logic led_d1,
  output logic led_d2,
  output logic led_d3,
  output logic led_d4,
  output logic led_d5
);

  localparam int unsigned BaudClks = CLK_HZ / BAUD;
  localparam int unsigned HalfClks = BaudClks / 2;
  localparam int unsigned CntW     = $clog2(BaudClks + 1);

  localparam logic [207:0] RotorI   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] RotorII  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] RotorIII = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
  localparam logic [207:0] ReflB    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [127:0] Banner   = {"ENIGMA-I READY", 8'h0d, 8'h0a};

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + 6'd26 - {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] wire_at(input logic [207:0] w, input logic [4:0] i);
    logic [7:0] ch;
    ch = w[{5'd25 - i, 3'b000} +: 8];
    return 5'(ch - 8'h41);
  endfunction

  function automatic logic [4:0] rotor_fwd(input logic [207:0] w, input logic [4:0] c,
                                           input logic [4:0] p);
    return sub26(wire_at(w, add26(c, p)), p);
  endfunction

  // Return path: search the wiring table for the contact that maps to x.
  function automatic logic [4:0] rotor_bwd(input logic [207:0] w, input logic [4:0] c,
                                           input logic [4:0] p);
    logic [4:0] x;
    logic [4:0] r;
    x = add26(c, p);
    r = 5'd0;
    for (int j = 0; j < 26; j++) begin
      if (wire_at(w, 5'(j)) == x) r = 5'(j);
    end
    return sub26(r, p);
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s1_d    = uart_rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntW'(HalfClks - 1)) begin
          rx_cnt_d = '0;
          // A start bit that is high at mid-bit was a glitch.
          if (rx_s2_q) rx_state_d = RxIdle;
          else begin
            rx_state_d = RxData;
            rx_bit_d   = 3'd0;
          end
        end else rx_cnt_d = rx_cnt_q + CntW'(1);
      end
      RxData: begin
        if (rx_cnt_q == CntW'(BaudClks - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CntW'(1);
      end
      RxStop: begin
        if (rx_cnt_q == CntW'(BaudClks - 1)) begin
          rx_state_d = RxIdle;
          if (rx_s2_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
          end
        end else rx_cnt_d = rx_cnt_q + CntW'(1);
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ext_rst) begin
      rx_state_q <= RxIdle;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // ---------------- UART transmitter ----------------
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_busy_q, tx_busy_d, tx_line_q, tx_line_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_line_d  = tx_line_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (!tx_busy_q) begin
      if (tx_start_q) begin
        tx_busy_d  = 1'b1;
        tx_line_d  = 1'b0;
        tx_shift_d = {1'b1, tx_byte_q};
        tx_cnt_d   = '0;
        tx_bit_d   = 4'd0;
      end
    end else if (tx_cnt_q == CntW'(BaudClks - 1)) begin
      tx_cnt_d = '0;
      // tx_bit_q counts bit periods already on the line; 9 means stop bit done.
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_line_d = 1'b1;
      end else begin
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else tx_cnt_d = tx_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (ext_rst) begin
      tx_busy_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 9'h1ff;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_line_q  <= tx_line_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // ---------------- Enigma datapath ----------------
  logic [4:0] pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
  logic [4:0] letter_q, letter_d;
  logic [4:0] e1, e2, e3, e4, e5, e6, e7;
  logic [7:0] enc_byte;

  always_comb begin
    e1 = rotor_fwd(RotorIII, letter_q, pos_r_q);
    e2 = rotor_fwd(RotorII, e1, pos_m_q);
    e3 = rotor_fwd(RotorI, e2, pos_l_q);
    e4 = wire_at(ReflB, e3);
    e5 = rotor_bwd(RotorI, e4, pos_l_q);
    e6 = rotor_bwd(RotorII, e5, pos_m_q);
    e7 = rotor_bwd(RotorIII, e6, pos_r_q);
    enc_byte = 8'h41 + {3'd0, e7};
  end

  // ---------------- Controller ----------------
  typedef enum logic [3:0] {
    StInit = 4'd0, StBanner = 4'd1, StIdle = 4'd2, StStep = 4'd3,
    StEncipher = 4'd4, StSend = 4'd5, StWaitTx = 4'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ban_idx_q, ban_idx_d;
  logic       busy_prev_q, busy_prev_d;
  logic       toggle_q, toggle_d;

  always_comb begin
    state_d     = state_q;
    ban_idx_d   = ban_idx_q;
    busy_prev_d = tx_busy_q;
    toggle_d    = toggle_q;
    tx_start_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    letter_d    = letter_q;
    pos_l_d     = pos_l_q;
    pos_m_d     = pos_m_q;
    pos_r_d     = pos_r_q;
    unique case (state_q)
      StInit: begin
        ban_idx_d = 4'd0;
`ifdef ENIGMA_BANNER_EN
        state_d = StBanner;
`else
        state_d = StIdle;
`endif
      end
      StBanner: begin
        // tx_start_q guards the cycle before tx_busy rises.
        if (!tx_start_q && !tx_busy_q) begin
          tx_start_d = 1'b1;
          tx_byte_d  = Banner[{~ban_idx_q, 3'b000} +: 8];
          ban_idx_d  = ban_idx_q + 4'd1;
          if (ban_idx_q == 4'd15) state_d = StWaitTx;
        end
      end
      StIdle: begin
        if (rx_valid_q) begin
          if (rx_data_q >= 8'h41 && rx_data_q <= 8'h5a) begin
            letter_d = 5'(rx_data_q - 8'h41);
            state_d  = StStep;
          end else if (rx_data_q >= 8'h61 && rx_data_q <= 8'h7a) begin
            letter_d = 5'(rx_data_q - 8'h61);
            state_d  = StStep;
          end else begin
            tx_byte_d = rx_data_q;
            state_d   = StSend;
          end
        end
      end
      StStep: begin
        // Rotor III turns over leaving V; rotor II at E steps itself and the left rotor.
        pos_r_d = inc26(pos_r_q);
        if (pos_r_q == 5'd21 || pos_m_q == 5'd4) pos_m_d = inc26(pos_m_q);
        if (pos_m_q == 5'd4) pos_l_d = inc26(pos_l_q);
        state_d = StEncipher;
      end
      StEncipher: begin
        tx_byte_d = enc_byte;
        toggle_d  = ~toggle_q;
        state_d   = StSend;
      end
      StSend: begin
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (busy_prev_q && !tx_busy_q) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ext_rst) begin
      state_q     <= StInit;
      ban_idx_q   <= 4'd0;
      busy_prev_q <= 1'b0;
      toggle_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= 8'd0;
      letter_q    <= 5'd0;
      pos_l_q     <= 5'd0;
      pos_m_q     <= 5'd0;
      pos_r_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      ban_idx_q   <= ban_idx_d;
      busy_prev_q <= busy_prev_d;
      toggle_q    <= toggle_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
      letter_q    <= letter_d;
      pos_l_q     <= pos_l_d;
      pos_m_q     <= pos_m_d;
      pos_r_q     <= pos_r_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign led_d1  = (state_q == StIdle);
  assign led_d2  = (rx_state_q != RxIdle);
  assign led_d3  = tx_busy_q;
  assign led_d4  = toggle_q;
  assign led_d5  = ~ext_rst;

endmodule

// File: tb/tb_enigma_top.sv
// Directed bench for enigma_top at a reduced bit period of 10 clocks.
module tb_enigma_top;
  localparam int unsigned ClkHz = 1000000;
  localparam int unsigned Baud  = 100000;
  localparam int unsigned Bit   = ClkHz / Baud;

  logic clk = 1'b0;
  logic ext_rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, led_d1, led_d2, led_d3, led_d4, led_d5;

  int n_checks = 0;
  int n_fail   = 0;

  enigma_top #(.CLK_HZ(ClkHz), .BAUD(Baud)) dut (
    .clk(clk), .ext_rst(ext_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .led_d1(led_d1), .led_d2(led_d2), .led_d3(led_d3), .led_d4(led_d4), .led_d5(led_d5)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic ok, input int budget);
    int t = 0;
    b  = 8'd0;
    ok = 1'b0;
    while (uart_tx !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (Bit / 2) @(negedge clk);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (Bit) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (Bit) @(negedge clk);
    ok = (uart_tx === 1'b1);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic ok);
    logic [7:0] r;
    logic       k;
    fork
      send_byte(tx);
      recv_byte(r, k, 3000);
    join
    rx = r;
    ok = k;
  endtask

  task automatic test_banner();
`ifdef ENIGMA_BANNER_EN
    logic [127:0] ban = {"ENIGMA-I READY", 8'h0d, 8'h0a};
    logic [7:0] b, e;
    logic ok;
    for (int i = 0; i < 16; i++) begin
      recv_byte(b, ok, 3000);
      e = ban[8*(15-i) +: 8];
      n_checks++;
      if (!ok || b !== e) begin
        n_fail++;
        $display("FAIL banner[%0d]: got %h ok=%0b, required %h", i, b, ok, e);
      end
    end
`else
    logic saw_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    n_checks++;
    if (saw_low) begin
      n_fail++;
      $display("FAIL no_banner: got activity on uart_tx, required idle line");
    end
`endif
    repeat (20) @(negedge clk);
    n_checks++;
    if (dut.state_q !== 4'd2 || led_d1 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_init: got state=%0d led_d1=%b, required 2/1", dut.state_q, led_d1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ext_rst = 1'b1;
    repeat (3) @(negedge clk);
    ext_rst = 1'b0;
    test_banner();
  endtask

  task automatic check_pos(input string name, input logic [14:0] exp);
    n_checks++;
    if ({dut.pos_l_q, dut.pos_m_q, dut.pos_r_q} !== exp) begin
      n_fail++;
      $display("FAIL %s: got pos %0d/%0d/%0d, required %0d/%0d/%0d", name, dut.pos_l_q,
               dut.pos_m_q, dut.pos_r_q, exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  task automatic test_reset();
    ext_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1 || {led_d5, led_d4, led_d3, led_d2, led_d1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx=%b leds=%b, required 1/00000", uart_tx,
               {led_d5, led_d4, led_d3, led_d2, led_d1});
    end
    n_checks++;
    if (dut.state_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required 0", dut.state_q);
    end
    check_pos("reset_pos", 15'd0);
    ext_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (led_d5 !== 1'b1) begin
      n_fail++;
      $display("FAIL led_d5: got %b, required 1", led_d5);
    end
    test_banner();
  endtask

  task automatic test_single_a();
    logic [7:0] r;
    logic ok;
    xfer(8'h41, r, ok);
    n_checks++;
    if (!ok || r !== 8'h42) begin
      n_fail++;
      $display("FAIL single_a: got %h ok=%0b, required 42", r, ok);
    end
    check_pos("single_a_pos", {5'd0, 5'd0, 5'd1});
    n_checks++;
    if (led_d4 !== 1'b1) begin
      n_fail++;
      $display("FAIL led_d4_toggle: got %b, required 1", led_d4);
    end
  endtask

  task automatic test_aaaaa();
    logic [39:0] exp_s = "BDZGO";
    logic [7:0] r, e;
    logic ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(8'h41, r, ok);
      e = exp_s[8*(4-i) +: 8];
      n_checks++;
      if (!ok || r !== e) begin
        n_fail++;
        $display("FAIL aaaaa[%0d]: got %h ok=%0b, required %h", i, r, ok, e);
      end
    end
  endtask

  task automatic test_fold_echo();
    logic [7:0] r;
    logic ok;
    do_reset();
    xfer(8'h61, r, ok);
    n_checks++;
    if (!ok || r !== 8'h42) begin
      n_fail++;
      $display("FAIL fold_lower: got %h ok=%0b, required 42", r, ok);
    end
    xfer(8'h31, r, ok);
    n_checks++;
    if (!ok || r !== 8'h31) begin
      n_fail++;
      $display("FAIL echo_digit: got %h ok=%0b, required 31", r, ok);
    end
    check_pos("echo_pos", {5'd0, 5'd0, 5'd1});
    n_checks++;
    if (led_d4 !== 1'b1) begin
      n_fail++;
      $display("FAIL echo_no_toggle: got %b, required 1", led_d4);
    end
  endtask

  task automatic test_drop();
    logic [7:0] r1, r2;
    logic ok1, ok2;
    do_reset();
    fork
      begin
        send_byte(8'h41);
        send_byte(8'h41);
      end
      begin
        recv_byte(r1, ok1, 3000);
        recv_byte(r2, ok2, 600);
      end
    join
    n_checks++;
    if (!ok1 || r1 !== 8'h42 || ok2) begin
      n_fail++;
      $display("FAIL drop_busy: got %h ok=%0b second_ok=%0b, required 42/1/0", r1, ok1, ok2);
    end
    check_pos("drop_pos", {5'd0, 5'd0, 5'd1});
  endtask

  task automatic test_rx_glitch();
    logic saw_low = 1'b0;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (led_d2 !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_led_d2_on: got %b, required 1", led_d2);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (led_d2 !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_rejected: got led_d2=%b, required 0", led_d2);
    end
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    n_checks++;
    if (saw_low || dut.state_q !== 4'd2) begin
      n_fail++;
      $display("FAIL glitch_no_byte: got tx_activity=%0b state=%0d, required 0/2", saw_low,
               dut.state_q);
    end
  endtask

  task automatic test_double_step();
    logic [7:0] r;
    logic ok;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 98; i++) begin
      xfer(8'h41, r, ok);
      if (!ok) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL step_run: got %0d lost replies, required 0", bad);
    end
    check_pos("pos_adu", {5'd0, 5'd3, 5'd20});
    xfer(8'h41, r, ok);
    check_pos("pos_adv", {5'd0, 5'd3, 5'd21});
    xfer(8'h41, r, ok);
    check_pos("pos_aew", {5'd0, 5'd4, 5'd22});
    xfer(8'h41, r, ok);
    check_pos("pos_bfx", {5'd1, 5'd5, 5'd23});
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] r;
    logic ok;
    int t = 0;
    fork
      send_byte(8'h41);
      begin
        while (uart_tx !== 1'b0 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        repeat (30) @(negedge clk);
      end
    join
    n_checks++;
    if (uart_tx !== 1'b0 || led_d3 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_tx_setup: got tx=%b busy=%b, required 0/1", uart_tx, led_d3);
    end
    ext_rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (uart_tx !== 1'b1 || led_d3 !== 1'b0 || dut.state_q !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_tx_abort: got tx=%b busy=%b state=%0d, required 1/0/0", uart_tx,
               led_d3, dut.state_q);
    end
    @(negedge clk);
    ext_rst = 1'b0;
    test_banner();
    xfer(8'h41, r, ok);
    n_checks++;
    if (!ok || r !== 8'h42) begin
      n_fail++;
      $display("FAIL after_abort_a: got %h ok=%0b, required 42", r, ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_rx_glitch();
    test_aaaaa();
    test_fold_echo();
    test_drop();
    test_double_step();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
